uart_transmissor: RTL
=====================

Name: uart_transmissor

Overview:
- Byte-level UART transmitter directly downstream of the game-event payload senders (difficulty, board, status).
- Accepts one byte per `iniciar_envio` pulse and serialises it on `tx` as start, 8 data bits LSB-first, optional parity, and 1 or 2 stop bits.
- Reports `uart_ocupado` back to the sender's payload controller, which paces event-code and payload bytes through it.

Parameters:
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s; CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer truncation).
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- iniciar_envio  input  1  start request; sampled only in OCIOSO.
- dado_entrada  input  8  byte to send; latched on the accepting edge.
- tx  output  1  serial line, idle high.
- uart_ocupado  output  1  high while a frame is in flight.
- byte_enviado  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (synchronous, active-high): tx=1, uart_ocupado=0, byte_enviado=0, state OCIOSO, counters cleared.
- All outputs are registered.
- FSM states: OCIOSO, START, DADOS, PARIDADE, STOP.
- OCIOSO, iniciar_envio=1 at edge E:
  - latch dado_entrada;
  - from E onward: tx=0, uart_ocupado=1, state START.
- Each bit is held exactly CLKS_PER_BIT cycles, timed by the baud counter.
- START → DADOS; DADOS sends bit 0..7 (3-bit index).
- After bit 7: → PARIDADE if PARITY≠0, else → STOP.
- Parity bit: even = XOR of the 8 data bits; odd = its inverse.
- STOP drives tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
- At the final edge of STOP:
  - state → OCIOSO, uart_ocupado=0, byte_enviado=1 for exactly one cycle;
  - tx stays 1.
- uart_ocupado is high for exactly N×CLKS_PER_BIT cycles, where N = 1 + 8 + (PARITY≠0) + STOP_BITS.
- iniciar_envio while busy: ignored, no queuing; the latched byte is not disturbed by dado_entrada changes.
- iniciar_envio held high: a new frame starts at the first edge in OCIOSO, i.e. exactly one idle tx=1 cycle after the stop bits.
- Reset mid-frame: frame aborted, tx=1 from the reset edge, no byte_enviado pulse.
- Reset has priority over iniciar_envio on the same edge.
- Elaboration checks, each an elaboration error:
  - CLKS_PER_BIT < 2;
  - PARITY not in {0,1,2};
  - STOP_BITS not in {1,2}.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum;
  - PARITY_NONE/EVEN/ODD constants;
  - function clks_per_bit(freq, baud);
  - frame_bits(parity, stop).
- Sub-module uart_baud_counter:
  - loadable down-counter of width $clog2(CLKS_PER_BIT);
  - restarts on `carregar`;
  - asserts `fim_bit` on the last cycle of each bit period.
- Transmitter = FSM + shift register + parity accumulator around that counter.

Test Plan:
Bench config: CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (CLKS_PER_BIT=10).
1. Assert reset 3 cycles, then idle 20 cycles → tx=1, uart_ocupado=0, byte_enviado=0 throughout.
2. PARITY=0, STOP_BITS=1, send 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1, each 10 cycles; uart_ocupado high exactly 100 cycles; byte_enviado single pulse at cycle 100.
3. PARITY=1 send 0x07 → parity bit 1, 110-cycle frame; PARITY=2 send 0x07 → parity bit 0.
4. Send 0x3C, pulse iniciar_envio with dado_entrada=0xFF at cycle 40 → waveform is 0x3C only; exactly one byte_enviado.
5. Send 0xA5, assert reset at cycle 35 → tx=1 and uart_ocupado=0 from the reset edge, no byte_enviado; subsequent send of 0x81 is correct.
6. STOP_BITS=2, iniciar_envio held high with 0x00 then 0x55 → two 110-cycle frames separated by exactly one idle cycle; two byte_enviado pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM states, parity modes
// and frame-timing arithmetic.
package uart_pkg;

   typedef enum logic [2:0] {
      OCIOSO,
      START,
      DADOS,
      PARIDADE,
      STOP
   } estado_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

   // Bits per frame: start + 8 data + optional parity + stop bits.
   function automatic int frame_bits(input int parity, input int stop);
      return 1 + 8 + ((parity != PARITY_NONE) ? 1 : 0) + stop;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: free-running down-counter, restarted by carregar, that
// flags the last clock of every bit period.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic clock,
   input  logic reset,
   input  logic carregar,
   output logic fim_bit
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] RECARGA = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] contagem;

   always_ff @(posedge clock) begin
      if (reset) begin
         contagem <= '0;
      end else if (carregar || (contagem == '0)) begin
         contagem <= RECARGA;
      end else begin
         contagem <= contagem - CW'(1);
      end
   end

   assign fim_bit = (contagem == '0);

endmodule

// File: rtl/uart_transmissor.sv
// Byte-level UART transmitter: start bit, 8 data bits LSB-first, optional
// parity, 1 or 2 stop bits. All outputs registered.
module uart_transmissor
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar_envio,
   input  logic [7:0] dado_entrada,
   output logic       tx,
   output logic       uart_ocupado,
   output logic       byte_enviado
);

   localparam int   CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam logic PARIDADE_INI = (PARITY == PARITY_ODD);
   localparam logic ULTIMO_STOP  = 1'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_err_cpb
      $error("uart_transmissor: CLOCK_FREQ/BAUD_RATE must be at least 2");
   end
   if ((PARITY != PARITY_NONE) && (PARITY != PARITY_EVEN) && (PARITY != PARITY_ODD)) begin : g_err_par
      $error("uart_transmissor: PARITY must be 0, 1 or 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_err_stop
      $error("uart_transmissor: STOP_BITS must be 1 or 2");
   end

   estado_t    estado;
   logic [7:0] deslocamento;
   logic       paridade;
   logic [2:0] indice;
   logic       stop_cnt;
   logic       carregar;
   logic       fim_bit;

   assign carregar = (estado == OCIOSO) && iniciar_envio;

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clock   (clock),
      .reset   (reset),
      .carregar(carregar),
      .fim_bit (fim_bit)
   );

   // tx is loaded one edge ahead with the next bit, so it stays registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado       <= OCIOSO;
         tx           <= 1'b1;
         uart_ocupado <= 1'b0;
         byte_enviado <= 1'b0;
         indice       <= '0;
         stop_cnt     <= 1'b0;
      end else begin
         byte_enviado <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (iniciar_envio) begin
                  deslocamento <= dado_entrada;
                  paridade     <= PARIDADE_INI;
                  tx           <= 1'b0;
                  uart_ocupado <= 1'b1;
                  estado       <= START;
               end
            end
            START: begin
               if (fim_bit) begin
                  tx     <= deslocamento[0];
                  indice <= '0;
                  estado <= DADOS;
               end
            end
            DADOS: begin
               if (fim_bit) begin
                  deslocamento <= {1'b0, deslocamento[7:1]};
                  paridade     <= paridade ^ deslocamento[0];
                  indice       <= indice + 3'd1;
                  if (indice == 3'd7) begin
                     if (PARITY != PARITY_NONE) begin
                        tx     <= paridade ^ deslocamento[0];
                        estado <= PARIDADE;
                     end else begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        estado   <= STOP;
                     end
                  end else begin
                     tx <= deslocamento[1];
                  end
               end
            end
            PARIDADE: begin
               if (fim_bit) begin
                  tx       <= 1'b1;
                  stop_cnt <= 1'b0;
                  estado   <= STOP;
               end
            end
            STOP: begin
               if (fim_bit) begin
                  if (stop_cnt == ULTIMO_STOP) begin
                     uart_ocupado <= 1'b0;
                     byte_enviado <= 1'b1;
                     estado       <= OCIOSO;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               tx           <= 1'b1;
               uart_ocupado <= 1'b0;
               estado       <= OCIOSO;
            end
         endcase
      end
   end

endmodule
